uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit sampling FSM and a
// first-word fall-through byte FIFO with valid/ready drain.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic                          uart_rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int DATA_W       = 8;

  // The IDLE cycle that first sees the low line counts as the first cycle of
  // the half bit, so START finishes one count earlier than HALF.
  localparam logic [CNT_W-1:0] START_END = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]      DEPTH_L   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [2:0]         idx, idx_nxt;
  logic               bit_we, push, ferr_nxt;
  logic [DATA_W-1:0]  shreg;

  logic               rx_sync_p0, rx_sync_p1, rx_s;

  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]      wptr, rptr;
  logic [AW:0]        count;
  logic               full, pop, wr_en;

  // Stage p0/p1: metastability filter on the asynchronous line
  always_ff @(posedge clk) begin
    if (!rst_) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= uart_rx;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  assign rx_s = rx_sync_p1;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    bit_we    = 1'b0;
    push      = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == START_END) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_nxt = '0;
          bit_we  = 1'b1;
          idx_nxt = idx + 3'd1;
          if (idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_nxt = '0;
          if (rx_s) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low break must not look like a stream of start bits
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (bit_we) shreg[idx] <= rx_s;
  end

  assign full  = (count == DEPTH_L);
  assign pop   = rx_valid && rx_ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // When full, wptr == rptr: a push with a same-cycle pop overwrites the
  // slot being read out this very cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= shreg;
  end

  assign rx_valid = (count != '0);
  assign rx_data  = rx_valid ? mem[rptr] : '0;
  assign fill     = count;
  assign busy     = (state != IDLE);

endmodule
